bit_serial_adder: RTL and testbench



---
 rtl/bit_serial_pkg.sv | 13 +
 rtl/bit_serial_adder_if.sv | 39 +++
 rtl/full_adder.sv | 14 +
 rtl/bit_serial_adder.sv | 113 +++++++++++
 tb/tb_bit_serial_adder.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/bit_serial_pkg.sv
// rtl/bit_serial_pkg.sv - shared types and constants for the bit-serial adder
// Contents: state_t (IDLE, RUN, DONE) sequencing states; DEFAULT_WIDTH operand width.
package bit_serial_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/bit_serial_adder_if.sv
// rtl/bit_serial_adder_if.sv - request/result bundle of the bit-serial adder
// Signals: start, a, b, cin (and sub when SERIAL_ADDER_SUB_EN is defined) from the
// requester; busy, done, sum, cout back from the adder.
// master modport: requester side. slave modport: adder side.
interface bit_serial_adder_if
  import bit_serial_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
`ifdef SERIAL_ADDER_SUB_EN
  logic             sub;
`endif
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (
`ifdef SERIAL_ADDER_SUB_EN
    output sub,
`endif
    output start, a, b, cin,
    input  busy, done, sum, cout
  );

  modport slave (
`ifdef SERIAL_ADDER_SUB_EN
    input  sub,
`endif
    input  start, a, b, cin,
    output busy, done, sum, cout
  );

endinterface

// File: rtl/full_adder.sv
// rtl/full_adder.sv - one-bit full adder datapath cell
// Ports: A, B, Cin (inputs); Sum, Cout (outputs). Purely combinational.
module full_adder (
  input  logic A,
  input  logic B,
  input  logic Cin,
  output logic Sum,
  output logic Cout
);

  assign Sum  = A ^ B ^ Cin;
  assign Cout = (A & B) | (Cin & (A ^ B));

endmodule

// File: rtl/bit_serial_adder.sv
// rtl/bit_serial_adder.sv - multi-cycle bit-serial adder around one full_adder cell
// Ports: clk, rst_n (async active-low), bus (bit_serial_adder_if.slave:
// start/a/b/cin[/sub] in, busy/done/sum/cout out).
// Optional feature macro: SERIAL_ADDER_SUB_EN adds the sub input (a - b).
module bit_serial_adder
  import bit_serial_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                clk,
  input  logic                rst_n,
  bit_serial_adder_if.slave   bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] shift_a, shift_b;
  logic [WIDTH-1:0] result_sr;
  logic [WIDTH-1:0] result_nxt;
  logic [WIDTH-1:0] sum_q;
  logic             carry;
  logic             cout_q;
  logic [CW-1:0]    bit_cnt;
  logic             last_bit;
  logic             fa_sum, fa_cout;
  logic             busy_c, done_c;

  full_adder u_full_adder (
    .A    (shift_a[0]),
    .B    (shift_b[0]),
    .Cin  (carry),
    .Sum  (fa_sum),
    .Cout (fa_cout)
  );

  assign last_bit = (bit_cnt == CW'(WIDTH - 1));

  // Result bits enter at the MSB; after WIDTH shifts the first bit lands at bit 0.
  assign result_nxt = {fa_sum, {(WIDTH-1){1'b0}}} | (result_sr >> 1);

  always_comb begin
    state_nxt = state;
    busy_c    = 1'b0;
    done_c    = 1'b0;
    case (state)
      IDLE: if (bus.start) state_nxt = RUN;
      RUN: begin
        busy_c = 1'b1;
        if (last_bit) state_nxt = DONE;
      end
      DONE: begin
        done_c    = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_a   <= '0;
      shift_b   <= '0;
      result_sr <= '0;
      sum_q     <= '0;
      carry     <= 1'b0;
      cout_q    <= 1'b0;
      bit_cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            shift_a   <= bus.a;
            result_sr <= '0;
            bit_cnt   <= '0;
`ifdef SERIAL_ADDER_SUB_EN
            // a - b computed as a + ~b + 1; cout=1 then means no borrow.
            shift_b   <= bus.sub ? ~bus.b : bus.b;
            carry     <= bus.sub ? 1'b1 : bus.cin;
`else
            shift_b   <= bus.b;
            carry     <= bus.cin;
`endif
          end
        end
        RUN: begin
          result_sr <= result_nxt;
          carry     <= fa_cout;
          shift_a   <= shift_a >> 1;
          shift_b   <= shift_b >> 1;
          bit_cnt   <= bit_cnt + CW'(1);
          // Visible outputs change only here, so partial results never show.
          if (last_bit) begin
            sum_q  <= result_nxt;
            cout_q <= fa_cout;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy = busy_c;
  assign bus.done = done_c;
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;

endmodule

// File: tb/tb_bit_serial_adder.sv
// tb/tb_bit_serial_adder.sv - self-checking bench for bit_serial_adder
module tb_bit_serial_adder;
  import bit_serial_pkg::*;

  localparam int WIDTH = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bit_serial_adder_if #(.WIDTH(WIDTH)) bus ();

  bit_serial_adder #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: {cout,sum} as plain integer arithmetic.
  function automatic logic [WIDTH:0] model_result(input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b,
                                                  input logic cin, input logic sub);
    longint r;
    if (sub) r = longint'(a) - longint'(b) + (longint'(1) << WIDTH);
    else     r = longint'(a) + longint'(b) + longint'(cin);
    return r[WIDTH:0];
  endfunction

  logic cur_sub;
`ifdef SERIAL_ADDER_SUB_EN
  assign cur_sub = bus.sub;
`else
  assign cur_sub = 1'b0;
`endif

  // Model phase: 0 idle, 1..WIDTH busy, WIDTH+1 done.
  int             m_t;
  logic [WIDTH:0] m_pending;
  logic [WIDTH:0] m_held;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_t       <= 0;
      m_held    <= '0;
      m_pending <= '0;
    end else if (m_t == 0) begin
      if (bus.start) begin
        m_t       <= 1;
        m_pending <= model_result(bus.a, bus.b, bus.cin, cur_sub);
      end
    end else if (m_t == WIDTH) begin
      m_t    <= WIDTH + 1;
      m_held <= m_pending;
    end else if (m_t == WIDTH + 1) begin
      m_t <= 0;
    end else begin
      m_t <= m_t + 1;
    end
  end

  always @(negedge clk) begin
    check("busy", 64'(bus.busy), 64'(m_t >= 1 && m_t <= WIDTH));
    check("done", 64'(bus.done), 64'(m_t == WIDTH + 1));
    check("sum",  64'(bus.sum),  64'(m_held[WIDTH-1:0]));
    check("cout", 64'(bus.cout), 64'(m_held[WIDTH]));
  end

  task automatic drive_idle();
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    bus.cin   = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
    bus.sub   = 1'b0;
`endif
  endtask

  task automatic run_op(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic cin, input logic sub,
                        input logic [WIDTH-1:0] exp_sum, input logic exp_cout,
                        input int inject_cyc, input bit inject_done);
    int cyc;
    int busy_cnt;
    bit seen;
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = a;
    bus.b     = b;
    bus.cin   = cin;
`ifdef SERIAL_ADDER_SUB_EN
    bus.sub   = sub;
`endif
    @(posedge clk);
    #1;
    drive_idle();
    bus.a = ~a;
    bus.b = ~b;
    cyc = 0;
    busy_cnt = 0;
    seen = 1'b0;
    while (!seen && cyc < 3 * WIDTH) begin
      @(negedge clk);
      cyc++;
      if (bus.busy) busy_cnt++;
      if (bus.done) seen = 1'b1;
      if (cyc == inject_cyc) begin
        bus.start = 1'b1;
        bus.a     = 8'h01;
        bus.b     = 8'h01;
      end else if (cyc == inject_cyc + 1) begin
        bus.start = 1'b0;
      end
    end
    check({tag, "_done_seen"}, 64'(seen), 64'd1);
    check({tag, "_done_cycle"}, 64'(cyc), 64'(WIDTH + 1));
    check({tag, "_busy_cycles"}, 64'(busy_cnt), 64'(WIDTH));
    check({tag, "_sum"}, 64'(bus.sum), 64'(exp_sum));
    check({tag, "_cout"}, 64'(bus.cout), 64'(exp_cout));
    if (inject_done) begin
      bus.start = 1'b1;
      bus.a     = 8'h01;
      bus.b     = 8'h01;
      @(negedge clk);
      bus.start = 1'b0;
    end
  endtask

  task automatic expect_quiet(input string tag, input logic [WIDTH-1:0] exp_sum, input logic exp_cout);
    int dones;
    dones = 0;
    repeat (2 * WIDTH) begin
      @(negedge clk);
      if (bus.done) dones++;
    end
    check({tag, "_no_done"}, 64'(dones), 64'd0);
    check({tag, "_sum_held"}, 64'(bus.sum), 64'(exp_sum));
    check({tag, "_cout_held"}, 64'(bus.cout), 64'(exp_cout));
  endtask

  initial begin
    drive_idle();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    check("rst_sum",  64'(bus.sum),  64'd0);
    check("rst_cout", 64'(bus.cout), 64'd0);
    #2 rst_n = 1'b1;

    run_op("add_35_4a", 8'h35, 8'h4A, 1'b0, 1'b0, 8'h7F, 1'b0, 0, 1'b0);
    run_op("add_ff_01", 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 0, 1'b0);
    run_op("add_ff_00_c", 8'hFF, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 0, 1'b0);
    run_op("add_zero", 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 0, 1'b0);
    run_op("add_80_80_c", 8'h80, 8'h80, 1'b1, 1'b0, 8'h01, 1'b1, 0, 1'b0);
    run_op("add_a5_5a", 8'hA5, 8'h5A, 1'b0, 1'b0, 8'hFF, 1'b0, 0, 1'b0);

    // Start pulses during RUN and during DONE must both be dropped.
    run_op("ignore", 8'h35, 8'h4A, 1'b0, 1'b0, 8'h7F, 1'b0, 3, 1'b1);
    expect_quiet("ignore", 8'h7F, 1'b0);

    // Reset in the middle of RUN clears outputs immediately and suppresses done.
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = 8'h35;
    bus.b     = 8'h4A;
    @(posedge clk);
    #1 drive_idle();
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_busy", 64'(bus.busy), 64'd0);
    check("midrst_sum",  64'(bus.sum),  64'd0);
    check("midrst_cout", 64'(bus.cout), 64'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    expect_quiet("midrst", 8'h00, 1'b0);
    run_op("after_rst", 8'h12, 8'h34, 1'b1, 1'b0, 8'h47, 1'b0, 0, 1'b0);

`ifdef SERIAL_ADDER_SUB_EN
    run_op("sub_10_01", 8'h10, 8'h01, 1'b0, 1'b1, 8'h0F, 1'b1, 0, 1'b0);
    run_op("sub_00_01", 8'h00, 8'h01, 1'b1, 1'b1, 8'hFF, 1'b0, 0, 1'b0);
    run_op("sub0_add", 8'h01, 8'h00, 1'b1, 1'b0, 8'h02, 1'b0, 0, 1'b0);
`endif

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
